// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: shared types and constants for the JTAG TAP responder.
//   tap_state_e    : 16-state 1149.1 TAP controller state, 4-bit encoding
//   INSTR_*        : instruction codes decoded by the responder
//   IR_CAPTURE     : value loaded into the IR shift register on Capture-IR
package jtag_tap_pkg;

  // Encoding follows the conventional 1149.1 reference values so debug
  // traces of tap_state_o read the same as in most JTAG tools.
  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SH_DR    = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SH_IR    = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  localparam logic [3:0] INSTR_IDCODE  = 4'b0001;
  localparam logic [3:0] INSTR_CONFREG = 4'b0110;
  localparam logic [3:0] INSTR_BYPASS  = 4'b1111;
  localparam logic [3:0] IR_CAPTURE    = 4'b0101;

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: IEEE 1149.1 TAP controller state register and next-state logic.
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset
//   tck_rise in one-clk pulse marking a synchronized TCK rising edge
//   tms     in  synchronized TMS
//   trst_n  in  synchronized active-low TAP reset (overrides tck_rise)
//   state   out current TAP state (registered)
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tck_rise,
  input  logic       tms,
  input  logic       trst_n,
  output tap_state_e state
);

  tap_state_e next_state;

  always_comb begin
    next_state = state;
    unique case (state)
      TAP_TLR:      next_state = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      next_state = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   next_state = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   next_state = tms ? TAP_EX1_DR   : TAP_SH_DR;
      TAP_SH_DR:    next_state = tms ? TAP_EX1_DR   : TAP_SH_DR;
      TAP_EX1_DR:   next_state = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: next_state = tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
      TAP_EX2_DR:   next_state = tms ? TAP_UPD_DR   : TAP_SH_DR;
      TAP_UPD_DR:   next_state = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   next_state = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   next_state = tms ? TAP_EX1_IR   : TAP_SH_IR;
      TAP_SH_IR:    next_state = tms ? TAP_EX1_IR   : TAP_SH_IR;
      TAP_EX1_IR:   next_state = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: next_state = tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
      TAP_EX2_IR:   next_state = tms ? TAP_UPD_IR   : TAP_SH_IR;
      TAP_UPD_IR:   next_state = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      next_state = TAP_TLR;
    endcase
  end

  // TRSTn takes priority over a coincident TCK rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n || !trst_n) begin
      state <= TAP_TLR;
    end else if (tck_rise) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: JTAG TAP target running entirely in the system clock.
// TCK/TMS/TDI/TRSTn are oversampled, TCK edges become one-clk pulses, and the
// TAP FSM, IR and data registers (BYPASS, IDCODE, CONFREG) advance on them.
// Ports:
//   clk_i          in  system clock
//   rst_n          in  synchronous active-low reset
//   jtag_tck_i     in  JTAG clock (sampled as data)
//   jtag_trst_ni   in  JTAG reset, active-low
//   jtag_tms_i     in  test mode select
//   jtag_tdi_i     in  test data in
//   jtag_tdo_o     out test data out, updated on TCK falling edge
//   jtag_tdo_oe_o  out high while in Shift-DR/Shift-IR (TCK falling edge timing)
//   conf_reg_o     out configuration register
//   conf_upd_o     out one-clk pulse when the confreg is updated
//   tap_state_o    out current TAP state for debug
// TCK high and low phases must each last at least SYNC_STAGES+2 clk_i periods.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h249511C3,
  parameter int          CONF_WIDTH   = 9,
  parameter int          SYNC_STAGES  = 2   // must be >= 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  jtag_tck_i,
  input  logic                  jtag_trst_ni,
  input  logic                  jtag_tms_i,
  input  logic                  jtag_tdi_i,
  output logic                  jtag_tdo_o,
  output logic                  jtag_tdo_oe_o,
  output logic [CONF_WIDTH-1:0] conf_reg_o,
  output logic                  conf_upd_o,
  output logic [3:0]            tap_state_o
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(INSTR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CONFREG = IR_WIDTH'(INSTR_CONFREG);
  localparam logic [IR_WIDTH-1:0] IR_CAP     = IR_WIDTH'(IR_CAPTURE);

  // Synchronizers: the output of each chain is its MSB.
  logic [SYNC_STAGES-1:0] tck_sync, trst_sync, tms_sync, tdi_sync;
  logic                   tck_prev;
  logic                   tck_s, trst_s, tms_s, tdi_s;
  logic                   tck_rise, tck_fall;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      tck_sync  <= '0;
      trst_sync <= '0;
      tms_sync  <= '0;
      tdi_sync  <= '0;
      tck_prev  <= 1'b0;
    end else begin
      tck_sync  <= {tck_sync[SYNC_STAGES-2:0],  jtag_tck_i};
      trst_sync <= {trst_sync[SYNC_STAGES-2:0], jtag_trst_ni};
      tms_sync  <= {tms_sync[SYNC_STAGES-2:0],  jtag_tms_i};
      tdi_sync  <= {tdi_sync[SYNC_STAGES-2:0],  jtag_tdi_i};
      tck_prev  <= tck_s;
    end
  end

  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign trst_s   = trst_sync[SYNC_STAGES-1];
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev;
  assign tck_fall = ~tck_s & tck_prev;

  tap_state_e state;

  jtag_tap_fsm u_fsm (
    .clk      (clk_i),
    .rst_n    (rst_n),
    .tck_rise (tck_rise),
    .tms      (tms_s),
    .trst_n   (trst_s),
    .state    (state)
  );

  assign tap_state_o = state;

  // Instruction and data registers.
  logic [IR_WIDTH-1:0]   ir, ir_shift;
  logic [31:0]           idcode_shift;
  logic [CONF_WIDTH-1:0] conf_shift;
  logic                  bypass_shift;
  logic                  sel_idcode, sel_conf;
  logic                  dr_lsb;

  // Any code other than IDCODE or CONFREG falls through to BYPASS.
  assign sel_idcode = (ir == IR_IDCODE);
  assign sel_conf   = (ir == IR_CONFREG);

  always_comb begin
    dr_lsb = bypass_shift;
    if (sel_idcode)    dr_lsb = idcode_shift[0];
    else if (sel_conf) dr_lsb = conf_shift[0];
  end

  // Actions on tck_rise use 'state' before the FSM register updates, which is
  // exactly the state held during the rising edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ir            <= IR_IDCODE;
      ir_shift      <= '0;
      idcode_shift  <= '0;
      conf_shift    <= '0;
      bypass_shift  <= 1'b0;
      conf_reg_o    <= '0;
      conf_upd_o    <= 1'b0;
      jtag_tdo_o    <= 1'b0;
      jtag_tdo_oe_o <= 1'b0;
    end else begin
      conf_upd_o <= 1'b0;

      if (!trst_s) begin
        // Partial shifts are dropped; the confreg itself survives TRSTn.
        ir           <= IR_IDCODE;
        ir_shift     <= '0;
        idcode_shift <= '0;
        conf_shift   <= '0;
        bypass_shift <= 1'b0;
      end else if (tck_rise) begin
        unique case (state)
          TAP_TLR:    ir       <= IR_IDCODE;
          TAP_CAP_IR: ir_shift <= IR_CAP;
          TAP_SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
          TAP_UPD_IR: ir       <= ir_shift;
          TAP_CAP_DR: begin
            if (sel_idcode)    idcode_shift <= IDCODE_VALUE;
            else if (sel_conf) conf_shift   <= conf_reg_o;
            else               bypass_shift <= 1'b0;
          end
          TAP_SH_DR: begin
            if (sel_idcode)    idcode_shift <= {tdi_s, idcode_shift[31:1]};
            else if (sel_conf) conf_shift   <= {tdi_s, conf_shift[CONF_WIDTH-1:1]};
            else               bypass_shift <= tdi_s;
          end
          TAP_UPD_DR: begin
            if (sel_conf) begin
              conf_reg_o <= conf_shift;
              conf_upd_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      // TDO launches on the falling edge so the host samples it stably on the
      // next rising edge; it holds its last value outside the shift states.
      if (tck_fall) begin
        jtag_tdo_oe_o <= (state == TAP_SH_DR) || (state == TAP_SH_IR);
        if (state == TAP_SH_IR)      jtag_tdo_o <= ir_shift[0];
        else if (state == TAP_SH_DR) jtag_tdo_o <= dr_lsb;
      end
    end
  end

endmodule
